// File: rtl/execute_stage.sv
// -----------------------------------------------------------------------------
// execute_stage
//
// EX stage of the 5-stage pipelined RISC-V core.
// - Selects forwarded operands (ID/EX value, writeback result, or the
//   registered EX/MEM ALU result).
// - Performs the ALU operation.
// - Resolves branches and jumps, and drives the fetch redirect
//   combinationally.
// - Registers results and pass-through control into the EX/MEM boundary.
//   That register holds its contents on stall_m and clears on rst.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   stall_m                  hold EX/MEM register
//   data1_E, data2_E         rs1/rs2 operands from ID/EX
//   RD_E                     destination register
//   imm_E                    extended immediate
//   pc_E, pcplus4_E          instruction PC and PC+4
//   B_J_E                    branch/jump type
//   alu_op_E                 ALU operation
//   alu_src_E                operand B select (0 rs2, 1 imm)
//   op1_src_E                operand A select (0 rs1, 1 pc)
//   memwrite_en_E, regwrite_en_E, extension_type_E, data_size_E, wb_src_E
//                            control passed through to MEM
//   forward_a, forward_b     forwarding selects from the hazard unit
//   wb_result_W              writeback-stage result
//   pc_src_E, pc_target_E    fetch redirect (combinational)
//   *_M                      registered EX/MEM outputs
// -----------------------------------------------------------------------------
module execute_stage #(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_m,
  input  logic [SIZE-1:0] data1_E,
  input  logic [SIZE-1:0] data2_E,
  input  logic [4:0]      RD_E,
  input  logic [SIZE-1:0] imm_E,
  input  logic [SIZE-1:0] pc_E,
  input  logic [SIZE-1:0] pcplus4_E,
  input  logic [2:0]      B_J_E,
  input  logic [3:0]      alu_op_E,
  input  logic            alu_src_E,
  input  logic            op1_src_E,
  input  logic            memwrite_en_E,
  input  logic            regwrite_en_E,
  input  logic            extension_type_E,
  input  logic [1:0]      data_size_E,
  input  logic [1:0]      wb_src_E,
  input  logic [1:0]      forward_a,
  input  logic [1:0]      forward_b,
  input  logic [SIZE-1:0] wb_result_W,
  output logic            pc_src_E,
  output logic [SIZE-1:0] pc_target_E,
  output logic [SIZE-1:0] alu_result_M,
  output logic [SIZE-1:0] write_data_M,
  output logic [SIZE-1:0] pcplus4_M,
  output logic [4:0]      RD_M,
  output logic            memwrite_en_M,
  output logic            regwrite_en_M,
  output logic            extension_type_M,
  output logic [1:0]      data_size_M,
  output logic [1:0]      wb_src_M
);

  logic [SIZE-1:0] srcA_fwd, srcB_fwd, op_a, op_b, alu_result;
  logic [4:0]      shamt;
  logic            taken;

  logic [SIZE-1:0] alu_result_q, write_data_q, pcplus4_q;
  logic [4:0]      rd_q;
  logic            memwrite_q, regwrite_q, ext_q;
  logic [1:0]      data_size_q, wb_src_q;

  // Forwarding: the MEM-stage source is the registered EX/MEM result, so a
  // held (stalled) value is still the one forwarded.
  always_comb begin
    srcA_fwd = data1_E;
    case (forward_a)
      2'b01:   srcA_fwd = wb_result_W;
      2'b10:   srcA_fwd = alu_result_q;
      default: srcA_fwd = data1_E;
    endcase
  end

  always_comb begin
    srcB_fwd = data2_E;
    case (forward_b)
      2'b01:   srcB_fwd = wb_result_W;
      2'b10:   srcB_fwd = alu_result_q;
      default: srcB_fwd = data2_E;
    endcase
  end

  assign op_a  = op1_src_E ? pc_E  : srcA_fwd;
  assign op_b  = alu_src_E ? imm_E : srcB_fwd;
  assign shamt = op_b[4:0];

  always_comb begin
    alu_result = '0;
    case (alu_op_E)
      4'd0:    alu_result = op_a + op_b;
      4'd1:    alu_result = op_a - op_b;
      4'd2:    alu_result = op_a << shamt;
      4'd3:    alu_result = {{(SIZE-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      4'd4:    alu_result = {{(SIZE-1){1'b0}}, (op_a < op_b)};
      4'd5:    alu_result = op_a ^ op_b;
      4'd6:    alu_result = op_a >> shamt;
      4'd7:    alu_result = $signed(op_a) >>> shamt;
      4'd8:    alu_result = op_a | op_b;
      4'd9:    alu_result = op_a & op_b;
      4'd10:   alu_result = op_b;
      default: alu_result = '0;
    endcase
  end

  // Branch comparisons always use the forwarded register operands, never
  // the ALU operand muxes, so they are independent of alu_op/alu_src.
  always_comb begin
    taken = 1'b0;
    case (B_J_E)
      3'b001:  taken = (srcA_fwd == srcB_fwd);
      3'b010:  taken = (srcA_fwd != srcB_fwd);
      3'b011:  taken = ($signed(srcA_fwd) <  $signed(srcB_fwd));
      3'b100:  taken = ($signed(srcA_fwd) >= $signed(srcB_fwd));
      3'b101:  taken = (srcA_fwd <  srcB_fwd);
      3'b110:  taken = (srcA_fwd >= srcB_fwd);
      3'b111:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  assign pc_src_E    = taken;
  // Jumps (JAL and JALR) take the ALU sum with bit 0 cleared; branches use
  // a dedicated pc + imm adder.
  assign pc_target_E = (B_J_E == 3'b111) ? {alu_result[SIZE-1:1], 1'b0}
                                         : (pc_E + imm_E);

  // EX/MEM register: reset wins over stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_result_q <= '0;
      write_data_q <= '0;
      pcplus4_q    <= '0;
      rd_q         <= '0;
      memwrite_q   <= 1'b0;
      regwrite_q   <= 1'b0;
      ext_q        <= 1'b0;
      data_size_q  <= '0;
      wb_src_q     <= '0;
    end else if (!stall_m) begin
      alu_result_q <= alu_result;
      write_data_q <= srcB_fwd;
      pcplus4_q    <= pcplus4_E;
      rd_q         <= RD_E;
      memwrite_q   <= memwrite_en_E;
      regwrite_q   <= regwrite_en_E;
      ext_q        <= extension_type_E;
      data_size_q  <= data_size_E;
      wb_src_q     <= wb_src_E;
    end
  end

  assign alu_result_M     = alu_result_q;
  assign write_data_M     = write_data_q;
  assign pcplus4_M        = pcplus4_q;
  assign RD_M             = rd_q;
  assign memwrite_en_M    = memwrite_q;
  assign regwrite_en_M    = regwrite_q;
  assign extension_type_M = ext_q;
  assign data_size_M      = data_size_q;
  assign wb_src_M         = wb_src_q;

endmodule

// File: tb/tb_execute_stage.sv
// -----------------------------------------------------------------------------
// tb_execute_stage
//
// Directed testbench for execute_stage.
// - Inputs are driven 1 ns after each rising edge.
// - Combinational outputs are checked a further 1 ns later.
// - Registered outputs are checked 1 ns after the edge that loads them.
// - Expected ALU results for each loading edge are queued in exp_q.
// -----------------------------------------------------------------------------
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst, stall_m;
  logic [31:0] data1_E, data2_E, imm_E, pc_E, pcplus4_E, wb_result_W;
  logic [4:0]  RD_E;
  logic [2:0]  B_J_E;
  logic [3:0]  alu_op_E;
  logic        alu_src_E, op1_src_E, memwrite_en_E, regwrite_en_E, extension_type_E;
  logic [1:0]  data_size_E, wb_src_E, forward_a, forward_b;
  logic        pc_src_E;
  logic [31:0] pc_target_E, alu_result_M, write_data_M, pcplus4_M;
  logic [4:0]  RD_M;
  logic        memwrite_en_M, regwrite_en_M, extension_type_M;
  logic [1:0]  data_size_M, wb_src_M;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  execute_stage #(.SIZE(32)) dut (
    .clk(clk), .rst(rst), .stall_m(stall_m),
    .data1_E(data1_E), .data2_E(data2_E), .RD_E(RD_E), .imm_E(imm_E),
    .pc_E(pc_E), .pcplus4_E(pcplus4_E), .B_J_E(B_J_E), .alu_op_E(alu_op_E),
    .alu_src_E(alu_src_E), .op1_src_E(op1_src_E),
    .memwrite_en_E(memwrite_en_E), .regwrite_en_E(regwrite_en_E),
    .extension_type_E(extension_type_E), .data_size_E(data_size_E),
    .wb_src_E(wb_src_E), .forward_a(forward_a), .forward_b(forward_b),
    .wb_result_W(wb_result_W), .pc_src_E(pc_src_E), .pc_target_E(pc_target_E),
    .alu_result_M(alu_result_M), .write_data_M(write_data_M),
    .pcplus4_M(pcplus4_M), .RD_M(RD_M), .memwrite_en_M(memwrite_en_M),
    .regwrite_en_M(regwrite_en_M), .extension_type_M(extension_type_M),
    .data_size_M(data_size_M), .wb_src_M(wb_src_M)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // advance to 1 ns after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // let combinational outputs settle after an input change
  task automatic settle();
    #1;
  endtask

  // pop the expected ALU result for the edge just taken
  task automatic check_alu_m(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_q_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, alu_result_M, e);
    end
  endtask

  task automatic clear_inputs();
    data1_E = '0; data2_E = '0; RD_E = '0; imm_E = '0; pc_E = '0;
    pcplus4_E = '0; B_J_E = '0; alu_op_E = '0; alu_src_E = 1'b0;
    op1_src_E = 1'b0; memwrite_en_E = 1'b0; regwrite_en_E = 1'b0;
    extension_type_E = 1'b0; data_size_E = '0; wb_src_E = '0;
    forward_a = '0; forward_b = '0; wb_result_W = '0;
  endtask

  task automatic drive_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    data1_E = a; data2_E = b; alu_op_E = op; alu_src_E = 1'b0; op1_src_E = 1'b0;
  endtask

  // branch vectors: type, rs1, rs2, expected taken
  logic [2:0]  br_type [6] = '{3'd1, 3'd1, 3'd2, 3'd4, 3'd6, 3'd3};
  logic [31:0] br_a    [6] = '{32'h5, 32'h5, 32'h5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h2};
  logic [31:0] br_b    [6] = '{32'h5, 32'h6, 32'h6, 32'h1, 32'h1, 32'h1};
  logic        br_exp  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    clear_inputs();
    rst = 1'b1; stall_m = 1'b0;
    // put non-zero values on inputs while in reset to prove reset wins
    drive_alu(32'd9, 32'd9, 4'd0); regwrite_en_E = 1'b1; pcplus4_E = 32'h44; RD_E = 5'd7;
    step(); step();
    check("rst_alu",   alu_result_M, 32'h0);
    check("rst_wdata", write_data_M, 32'h0);
    check("rst_pc4",   pcplus4_M, 32'h0);
    check("rst_rd",    {27'd0, RD_M}, 32'h0);
    check("rst_ctrl",  {25'd0, memwrite_en_M, regwrite_en_M, extension_type_M,
                        data_size_M, wb_src_M}, 32'h0);

    // ADD 5 + 7 with control pass-through
    rst = 1'b0;
    clear_inputs();
    drive_alu(32'd5, 32'd7, 4'd0);
    RD_E = 5'd3; regwrite_en_E = 1'b1; memwrite_en_E = 1'b1; extension_type_E = 1'b1;
    data_size_E = 2'b10; wb_src_E = 2'b01; pcplus4_E = 32'h104;
    settle();
    check("add_pcsrc", {31'd0, pc_src_E}, 32'd0);
    exp_q.push_back(32'd12);
    step();
    check_alu_m("add_res");
    check("add_wdata", write_data_M, 32'd7);
    check("add_rd",    {27'd0, RD_M}, 32'd3);
    check("add_ctrl",  {25'd0, memwrite_en_M, regwrite_en_M, extension_type_M,
                        data_size_M, wb_src_M}, {25'd0, 3'b111, 2'b10, 2'b01});

    // forwarding: first put 0x100 into EX/MEM, then SUB with both forwarded
    clear_inputs();
    drive_alu(32'h100, 32'h0, 4'd0);
    exp_q.push_back(32'h100);
    step();
    check_alu_m("fwd_setup");
    drive_alu(32'hDEAD, 32'hBEEF, 4'd1);
    forward_a = 2'b10; forward_b = 2'b01; wb_result_W = 32'h3;
    exp_q.push_back(32'hFD);
    step();
    check_alu_m("fwd_sub");
    check("fwd_wdata", write_data_M, 32'h3);

    // branches
    clear_inputs();
    data1_E = 32'hFFFF_FFFF; data2_E = 32'h1; pc_E = 32'h40; imm_E = 32'h10;
    alu_op_E = 4'd1; B_J_E = 3'b011;
    settle();
    check("blt_pcsrc",  {31'd0, pc_src_E}, 32'd1);
    check("blt_target", pc_target_E, 32'h50);
    B_J_E = 3'b101;
    settle();
    check("bltu_pcsrc", {31'd0, pc_src_E}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      B_J_E = br_type[i]; data1_E = br_a[i]; data2_E = br_b[i];
      settle();
      check($sformatf("br_vec%0d", i), {31'd0, pc_src_E}, {31'd0, br_exp[i]});
    end

    // JALR
    clear_inputs();
    data1_E = 32'h1003; imm_E = 32'h4; alu_src_E = 1'b1; op1_src_E = 1'b0;
    alu_op_E = 4'd0; B_J_E = 3'b111; pcplus4_E = 32'h2004; pc_E = 32'h2000;
    settle();
    check("jalr_pcsrc",  {31'd0, pc_src_E}, 32'd1);
    check("jalr_target", pc_target_E, 32'h1006);
    exp_q.push_back(32'h1007);
    step();
    check_alu_m("jalr_res");
    check("jalr_pc4", pcplus4_M, 32'h2004);

    // JAL: pc + imm through the ALU
    op1_src_E = 1'b1; pc_E = 32'h300; imm_E = 32'h20; data1_E = 32'h0;
    settle();
    check("jal_target", pc_target_E, 32'h320);

    // stall holds EX/MEM, forwarding still sees the held value
    clear_inputs();
    drive_alu(32'hAA, 32'h0, 4'd0); pcplus4_E = 32'h55;
    exp_q.push_back(32'hAA);
    step();
    check_alu_m("stall_load");
    stall_m = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_alu($urandom_range(1000, 1), $urandom_range(1000, 1), 4'd0);
      pcplus4_E = $urandom_range(1000, 1);
      step();
      check($sformatf("stall_hold%0d", i), alu_result_M, 32'hAA);
      check($sformatf("stall_pc4_%0d", i), pcplus4_M, 32'h55);
    end
    forward_a = 2'b10; data2_E = 32'hAA; B_J_E = 3'b001;
    settle();
    check("stall_fwd_beq", {31'd0, pc_src_E}, 32'd1);
    rst = 1'b1;
    step();
    check("rst_over_stall", alu_result_M, 32'h0);
    check("rst_over_stall_pc4", pcplus4_M, 32'h0);
    rst = 1'b0; stall_m = 1'b0;

    // shifts and unused op
    clear_inputs();
    drive_alu(32'h8000_0000, 32'h24, 4'd7);
    exp_q.push_back(32'hF800_0000);
    step();
    check_alu_m("sra");
    drive_alu(32'h1234, 32'h5678, 4'd13);
    exp_q.push_back(32'h0);
    step();
    check_alu_m("op13");

    // bubble
    clear_inputs();
    regwrite_en_E = 1'b1; memwrite_en_E = 1'b1;
    step();
    clear_inputs();
    settle();
    check("bubble_pcsrc", {31'd0, pc_src_E}, 32'd0);
    step();
    check("bubble_we", {30'd0, regwrite_en_M, memwrite_en_M}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- EX stage of the 5-stage pipelined RISC-V core. It sits directly downstream of the ID/EX register and consumes that register's outputs (operands, immediate, PC, control).
- Applies forwarding, performs the ALU operation and resolves branches and jumps. It drives the PC redirect back to fetch.
- Registers results into the EX/MEM boundary consumed by the memory stage.
- The EX/MEM register is internal to this block and supports a hold (memory stall).

Parameters:
- SIZE, 32, datapath/address width.

Ports:
- clk  input  1  clock, all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- stall_m  input  1  hold EX/MEM register contents.
- data1_E, data2_E  input  SIZE  register-file operands from ID/EX.
- RD_E  input  5  destination register.
- imm_E  input  SIZE  extended immediate.
- pc_E, pcplus4_E  input  SIZE  instruction PC and PC+4.
- B_J_E  input  3  branch/jump type.
- alu_op_E  input  4  ALU operation.
- alu_src_E  input  1  operand B select: 0 = forwarded rs2, 1 = imm.
- op1_src_E  input  1  operand A select: 0 = forwarded rs1, 1 = pc.
- memwrite_en_E, regwrite_en_E, extension_type_E  input  1  control bits passed through.
- data_size_E, wb_src_E  input  2  control fields passed through.
- forward_a, forward_b  input  2  forwarding selects from the hazard unit.
- wb_result_W  input  SIZE  writeback-stage result.
- pc_src_E  output  1  redirect fetch (combinational).
- pc_target_E  output  SIZE  redirect address (combinational).
- alu_result_M, write_data_M, pcplus4_M  output  SIZE  registered results.
- RD_M  output  5  registered destination register.
- memwrite_en_M, regwrite_en_M, extension_type_M  output  1  registered control.
- data_size_M, wb_src_M  output  2  registered control.

Behaviour:
- Forwarding selects:
  - 00 = ID/EX operand.
  - 01 = wb_result_W.
  - 10 = alu_result_M.
  - 11 = ID/EX operand.
- Forwarded rs2 (srcB_fwd) is also the store data.
- Operand A = op1_src_E ? pc_E : forwarded rs1.
- Operand B = alu_src_E ? imm_E : srcB_fwd.
- alu_op encoding:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT (signed), 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B (LUI).
  - 11–15 produce 0.
  - Shifts use B[4:0] only.
  - All arithmetic is modulo 2^SIZE with no overflow flag.
- B_J_E encoding:
  - 000 none.
  - 001 BEQ, 010 BNE, 011 BLT, 100 BGE, 101 BLTU, 110 BGEU.
  - 111 jump.
  - All comparisons are between forwarded rs1 and srcB_fwd, independent of alu_op.
- pc_src_E:
  - Equals 1 for a taken branch or B_J_E = 111.
  - Otherwise 0.
  - Fully combinational; valid in the same cycle the instruction sits in EX.
- pc_target_E:
  - Branches: pc_E + imm_E.
  - Jump: ALU result with bit 0 cleared. This covers JAL (op1_src = 1, ADD) and JALR (op1_src = 0, ADD).
- EX/MEM register update on posedge clk:
  - rst = 1: every registered output becomes 0. rst overrides stall_m.
  - rst = 0, stall_m = 1: all registered outputs hold their values.
  - Otherwise: load alu_result, srcB_fwd → write_data_M, pcplus4_E, RD_E and the control bits.
- Latency: one cycle from EX inputs to the _M outputs; zero cycles for pc_src_E / pc_target_E.
- The forwarding path from alu_result_M uses the registered value, including while stall_m holds it.
- pc_src_E is not gated by stall_m. The hazard unit is responsible for freezing the upstream stages.
- A bubble (all-zero ID/EX contents) produces regwrite_en_M = 0, memwrite_en_M = 0 and pc_src_E = 0. A bubble never redirects.
- Reset mid-operation discards the in-flight EX/MEM contents with no partial update.

Test Plan:
- Reset and ADD:
  - Stimulus: rst high 2 cycles, then ADD with data1 = 5, data2 = 7, alu_src = 0.
  - Required: all _M outputs 0 during reset; alu_result_M = 12 one cycle after release; pc_src_E = 0.
- Forwarding:
  - Stimulus: forward_a = 10 with alu_result_M = 0x100, forward_b = 01 with wb_result_W = 0x3, SUB.
  - Required: next alu_result_M = 0xFD, write_data_M = 0x3.
- Branches:
  - Stimulus: BLT with rs1 = 0xFFFFFFFF, rs2 = 1, pc = 0x40, imm = 0x10.
  - Required: pc_src_E = 1, pc_target_E = 0x50.
  - Stimulus: same operands with BLTU.
  - Required: pc_src_E = 0.
- JALR:
  - Stimulus: op1_src = 0, rs1 = 0x1003, imm = 4, ADD, B_J = 111.
  - Required: pc_target_E = 0x1006; pcplus4_M = pcplus4_E next cycle.
- Stall and reset priority:
  - Stimulus: load alu_result_M = 0xAA, then stall_m high 3 cycles while inputs change.
  - Required: outputs stay 0xAA.
  - Stimulus: assert rst together with stall_m.
  - Required: outputs become 0 next edge.
- Shifts and default op:
  - Stimulus: SRA 0x80000000 by B = 0x24.
  - Required: 0xF8000000 (shift amount 4).
  - Stimulus: alu_op = 13.
  - Required: result 0.
